// File: rtl/video_frame_wrtr_pkg.sv
// Shared register map, FSM state encoding and small helpers for the video frame writer.
package video_frame_wrtr_pkg;

   localparam logic [7:0] REG_CONFIG    = 8'h00;
   localparam logic [7:0] REG_STATUS    = 8'h04;
   localparam logic [7:0] REG_HRES      = 8'h08;
   localparam logic [7:0] REG_VRES      = 8'h0C;
   localparam logic [7:0] REG_FRAME_CNT = 8'h10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_e;

   typedef struct packed {
      logic busy;
      logic frame_done;
      logic ovrflw;
   } status_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hffff) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; push-to-read latency 1 cycle.
// Push while full is dropped, pop while empty is ignored; no backpressure beyond full/empty.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_nxt(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign pop_dat = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = do_push ? ptr_nxt(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop  ? ptr_nxt(rd_ptr_q) : rd_ptr_q;
      cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat;
   end

endmodule

// File: rtl/video_frame_wrtr.sv
// Captures registered RGB video into a pixel FIFO (2 cycles after the pin) and writes it to memory one word per handshake.
// sys_mem_wait stalls the pending write; a full FIFO drops pixels and flags ovrflw, video is never backpressured.
module video_frame_wrtr
   import video_frame_wrtr_pkg::*;
#(
   parameter int                   LB_DATA_W              = 32,
   parameter int                   LB_ADDR_W              = 8,
   parameter int                   SYS_MEM_DATA_W         = 32,
   parameter int                   SYS_MEM_ADDR_W         = 27,
   parameter int                   SYS_MEM_START_ADDR     = 0,
   parameter int                   SYS_MEM_STOP_ADDR      = 921599,
   parameter bit                   SYNC_ACTIVE_HIGH_N_LOW = 1'b0,
   parameter int                   FIFO_DEPTH             = 16,
   parameter logic [LB_DATA_W-1:0] DEFAULT_REG_VAL        = 32'hdeadbabe
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      lb_wr_en,
   input  logic                      lb_rd_en,
   input  logic [LB_ADDR_W-1:0]      lb_addr,
   input  logic [LB_DATA_W-1:0]      lb_wr_data,
   output logic                      lb_wr_valid,
   output logic                      lb_rd_valid,
   output logic [LB_DATA_W-1:0]      lb_rd_data,
   input  logic [23:0]               vid_d,
   input  logic                      vid_de,
   input  logic                      vid_hs,
   input  logic                      vid_vs,
   input  logic                      sys_mem_wait,
   output logic                      sys_mem_wren,
   output logic                      sys_mem_rden,
   output logic [SYS_MEM_ADDR_W-1:0] sys_mem_addr,
   output logic [SYS_MEM_DATA_W-1:0] sys_mem_wdata
);

   localparam logic [SYS_MEM_ADDR_W-1:0] START_A = SYS_MEM_ADDR_W'(SYS_MEM_START_ADDR);
   localparam logic [SYS_MEM_ADDR_W-1:0] STOP_A  = SYS_MEM_ADDR_W'(SYS_MEM_STOP_ADDR);

   logic [23:0]               vid_d_q;
   logic                      vid_de_q, vid_vs_q, vs_prev_q, de_prev_q;
   state_e                    state_q, state_d;
   logic                      cap_en_q, cap_en_d, single_shot_q, single_shot_d;
   logic                      ovf_q, ovf_d, frame_done_q, frame_done_d;
   logic                      reload_q, reload_d, wren_q, wren_d;
   logic [SYS_MEM_ADDR_W-1:0] addr_q, addr_d;
   logic [SYS_MEM_DATA_W-1:0] wdata_q, wdata_d;
   logic [15:0]               hcnt_q, hcnt_d, hres_q, hres_d, vcnt_q, vcnt_d;
   logic [15:0]               vres_q, vres_d, frame_cnt_q, frame_cnt_d;
   logic                      wr_vld_q, rd_vld_q;
   logic [LB_DATA_W-1:0]      rd_dat_q, rd_dat_d;

   logic        vs_edge, cfg_wr, sts_wr, push, load, wr_done, busy, frame_end;
   logic        fifo_full, fifo_empty;
   logic [31:0] fifo_dout;
   status_t     sts_rd;
   logic        unused_ok;

   assign unused_ok = ^{vid_hs, lb_wr_data[LB_DATA_W-1:2]};

   assign vs_edge = SYNC_ACTIVE_HIGH_N_LOW ? (vid_vs_q & ~vs_prev_q) : (~vid_vs_q & vs_prev_q);
   assign cfg_wr  = lb_wr_en && (lb_addr == LB_ADDR_W'(REG_CONFIG));
   assign sts_wr  = lb_wr_en && (lb_addr == LB_ADDR_W'(REG_STATUS));
   assign push    = (state_q == ST_CAPTURE) && vid_de_q;
   assign wr_done = wren_q & ~sys_mem_wait;
   // The pending write holds one popped word, so the FIFO refills while memory stalls.
   assign load    = ~fifo_empty & (~wren_q | ~sys_mem_wait);
   assign busy    = (state_q != ST_IDLE) | ~fifo_empty;
   assign sts_rd  = '{busy: busy, frame_done: frame_done_q, ovrflw: ovf_q};

   sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_dat ({8'h00, vid_d_q}),
      .pop      (load),
      .pop_dat  (fifo_dout),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_comb begin
      state_d       = state_q;
      cap_en_d      = cap_en_q;
      single_shot_d = single_shot_q;
      ovf_d         = ovf_q;
      frame_done_d  = frame_done_q;
      reload_d      = reload_q;
      wren_d        = wren_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      hcnt_d        = hcnt_q;
      hres_d        = hres_q;
      vcnt_d        = vcnt_q;
      vres_d        = vres_q;
      frame_cnt_d   = frame_cnt_q;
      frame_end     = 1'b0;
      rd_dat_d      = '0;

      if (cfg_wr) begin
         cap_en_d      = lb_wr_data[0];
         single_shot_d = lb_wr_data[1];
      end

      case (state_q)
         ST_IDLE:    if (cap_en_q) state_d = ST_ARMED;
         ST_ARMED: begin
            if (!cap_en_q) state_d = ST_IDLE;
            else if (vs_edge) begin
               state_d  = ST_CAPTURE;
               reload_d = 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (vs_edge) begin
               frame_end = 1'b1;
               if (single_shot_q || !cap_en_q) begin
                  state_d = ST_IDLE;
                  if (single_shot_q) cap_en_d = 1'b0;
               end else begin
                  state_d = ST_ARMED;
               end
            end
         end
         default:    state_d = ST_IDLE;
      endcase

      if (sts_wr && lb_wr_data[0]) ovf_d = 1'b0;
      if (push && fifo_full)       ovf_d = 1'b1;
      if (sts_wr && lb_wr_data[1]) frame_done_d = 1'b0;
      if (frame_end) begin
         frame_done_d = 1'b1;
         frame_cnt_d  = frame_cnt_q + 16'd1;
      end

      if (vid_de_q) hcnt_d = de_prev_q ? sat_inc16(hcnt_q) : 16'd1;
      if (de_prev_q && !vid_de_q) hres_d = hcnt_q;
      if (vid_de_q && !de_prev_q) vcnt_d = sat_inc16(vcnt_q);
      if (vs_edge) begin
         vres_d = vcnt_q;
         vcnt_d = 16'd0;
      end

      // Address reload waits until the previous frame has fully drained.
      if (wr_done) addr_d = (addr_q == STOP_A) ? START_A : addr_q + SYS_MEM_ADDR_W'(1);
      else if (reload_q && fifo_empty && !wren_q) begin
         addr_d   = START_A;
         reload_d = 1'b0;
      end
      if (load) begin
         wren_d  = 1'b1;
         wdata_d = SYS_MEM_DATA_W'(fifo_dout);
      end else if (wr_done) begin
         wren_d  = 1'b0;
      end

      if (lb_rd_en) begin
         case (lb_addr)
            LB_ADDR_W'(REG_CONFIG):    rd_dat_d = LB_DATA_W'({single_shot_q, cap_en_q});
            LB_ADDR_W'(REG_STATUS):    rd_dat_d = LB_DATA_W'(sts_rd);
            LB_ADDR_W'(REG_HRES):      rd_dat_d = LB_DATA_W'(hres_q);
            LB_ADDR_W'(REG_VRES):      rd_dat_d = LB_DATA_W'(vres_q);
            LB_ADDR_W'(REG_FRAME_CNT): rd_dat_d = LB_DATA_W'(frame_cnt_q);
            default:                   rd_dat_d = DEFAULT_REG_VAL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vid_d_q       <= '0;
         vid_de_q      <= 1'b0;
         vid_vs_q      <= 1'b0;
         vs_prev_q     <= 1'b0;
         de_prev_q     <= 1'b0;
         state_q       <= ST_IDLE;
         cap_en_q      <= 1'b0;
         single_shot_q <= 1'b0;
         ovf_q         <= 1'b0;
         frame_done_q  <= 1'b0;
         reload_q      <= 1'b0;
         wren_q        <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         hcnt_q        <= '0;
         hres_q        <= '0;
         vcnt_q        <= '0;
         vres_q        <= '0;
         frame_cnt_q   <= '0;
         wr_vld_q      <= 1'b0;
         rd_vld_q      <= 1'b0;
         rd_dat_q      <= '0;
      end else begin
         vid_d_q       <= vid_d;
         vid_de_q      <= vid_de;
         vid_vs_q      <= vid_vs;
         vs_prev_q     <= vid_vs_q;
         de_prev_q     <= vid_de_q;
         state_q       <= state_d;
         cap_en_q      <= cap_en_d;
         single_shot_q <= single_shot_d;
         ovf_q         <= ovf_d;
         frame_done_q  <= frame_done_d;
         reload_q      <= reload_d;
         wren_q        <= wren_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         hcnt_q        <= hcnt_d;
         hres_q        <= hres_d;
         vcnt_q        <= vcnt_d;
         vres_q        <= vres_d;
         frame_cnt_q   <= frame_cnt_d;
         wr_vld_q      <= lb_wr_en;
         rd_vld_q      <= lb_rd_en;
         rd_dat_q      <= rd_dat_d;
      end
   end

   assign lb_wr_valid   = wr_vld_q;
   assign lb_rd_valid   = rd_vld_q;
   assign lb_rd_data    = rd_dat_q;
   assign sys_mem_wren  = wren_q;
   assign sys_mem_rden  = 1'b0;
   assign sys_mem_addr  = addr_q;
   assign sys_mem_wdata = wdata_q;

endmodule

// File: doc/video_frame_wrtr.md
VIDEO_FRAME_WRTR -- requirements
Module: video_frame_wrtr

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- LB_DATA_W, 32, local bus data width.
- LB_ADDR_W, 8, local bus address width.
- SYS_MEM_DATA_W, 32, system memory data width.
- SYS_MEM_ADDR_W, 27, system memory word address width.
- SYS_MEM_START_ADDR, 0, first frame word address.
- SYS_MEM_STOP_ADDR, 921599, last frame word address.
- SYNC_ACTIVE_HIGH_N_LOW, 0, 1 = HS/VS active high.
- FIFO_DEPTH, 16, pixel FIFO entries.
- DEFAULT_REG_VAL, 'hdeadbabe, read data for unmapped addresses.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; reset is asynchronous and active-low.
- rst_n, in, 1, asynchronous active-low reset.
- lb_wr_en / lb_rd_en, in, 1, local bus write / read strobe.
- lb_addr, in, LB_ADDR_W, register address.
- lb_wr_data, in, LB_DATA_W, write data.
- lb_wr_valid / lb_rd_valid, out, 1, write / read acknowledge.
- lb_rd_data, out, LB_DATA_W, read data.
- vid_d, in, 24, RGB pixel.
- vid_de, in, 1, active video.
- vid_hs / vid_vs, in, 1, syncs.
- sys_mem_wait, in, 1, memory stall.
- sys_mem_wren / sys_mem_rden, out, 1, write / read request (rden tied 0).
- sys_mem_addr, out, SYS_MEM_ADDR_W, word address.
- sys_mem_wdata, out, SYS_MEM_DATA_W, write data.

Function
REQ-003 Register map: CONFIG (bit0 cap_en, bit1 single_shot); STATUS (bit0 ovrflw, bit1 frame_done, bit2 busy); HRES (16b); VRES (16b); FRAME_CNT (16b).
- lb_wr_valid / lb_rd_valid = strobe delayed 1 cycle.
- Unmapped reads return DEFAULT_REG_VAL.
REQ-004 Writing 1 to STATUS bit0 or bit1 clears that bit; a same-cycle set event wins over the clear.
REQ-005 vs_edge = VS transition into the active level per SYNC_ACTIVE_HIGH_N_LOW; vid_* inputs registered once before use.
REQ-006 FSM states:
- IDLE -> ARMED when cap_en = 1.
- ARMED -> CAPTURE on vs_edge.
- CAPTURE -> ARMED on next vs_edge (frame_done set, FRAME_CNT++), or -> IDLE on that vs_edge if single_shot = 1 or cap_en = 0.
- cap_en = 0 mid-frame: capture continues until the next vs_edge.
REQ-007 In CAPTURE, each registered DE cycle pushes {8'h00, vid_d} into the FIFO, 2 cycles after the pin.
REQ-008 A push to a full FIFO drops the pixel and sets sticky ovrflw; no backpressure to video.
REQ-009 Memory write handshake:
- When the FIFO is non-empty and no write is pending: assert sys_mem_wren with FIFO head data and the current address.
- Hold wren/addr/wdata stable while sys_mem_wait = 1.
- Pop, increment address and deassert or reissue the write on the first cycle with wait = 0.
REQ-010 Addressing:
- Address loads SYS_MEM_START_ADDR on ARMED -> CAPTURE.
- After writing SYS_MEM_STOP_ADDR, the address wraps to SYS_MEM_START_ADDR.
- A vs_edge never truncates an in-flight write; FIFO contents drain to the old frame addresses before the address reload.
REQ-011 busy = state != IDLE or FIFO non-empty.
REQ-012 HRES latches the DE-high count of each line on DE falling edge.
REQ-013 VRES counts DE rising edges and latches on vs_edge; both counters are 16b saturating.

Reset
REQ-014 On rst_n low, all outputs go to 0:
- lb_wr_valid, lb_rd_valid, lb_rd_data, sys_mem_wren, sys_mem_rden, sys_mem_addr, sys_mem_wdata.
- All CSRs 0, FSM IDLE, FIFO empty, counters 0.
REQ-015 Reset mid-write drops the pending write without a handshake; no state survives.

Structure
REQ-016 Register addresses and the FSM state enum go in a shared package video_frame_wrtr_pkg.
REQ-017 The pixel FIFO is a separate sub-module sync_fifo (parameters WIDTH = 32, DEPTH = FIFO_DEPTH; ports full/empty/push/pop).

Verification
REQ-018 Scenarios:
- 4x3 active frame, wait = 0, cap_en = 1 -> 12 writes at addr 0..11, data {8'h00, pixel}, HRES = 4, VRES = 3, FRAME_CNT = 1, frame_done = 1.
- wait held high 40 cycles during a 32-pixel line -> ovrflw = 1; exactly FIFO_DEPTH + 1 writes (FIFO plus the one pending) complete before the drop; wren/addr stable throughout the stall.
- STOP_ADDR = 9, two 4x3 frames back-to-back with no VS -> address sequence wraps 9 -> 0.
- single_shot = 1 -> after the second vs_edge state is IDLE, busy drops once the FIFO drains, and no further writes occur.
- rst_n pulsed low mid-burst -> all outputs 0 within the reset assertion; after release, CONFIG reads 0 and unmapped address 0xFF reads 0xdeadbabe.
- STATUS write 0x1 in the same cycle as an overflow event -> ovrflw remains 1.
